// File: rtl/shift_merge_pipe_24.sv
// Two-stage shift/mask/merge execute unit (EXTR, DEP, DSR) for the 24-bit datapath.
// S1 registers operands and derives mask bounds; S2 shifts, masks, merges behind valid/ready.
module shift_merge_pipe_24 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  op,
  input  logic        sgn,
  input  logic        zro,
  input  logic [4:0]  pos,
  input  logic [4:0]  len,
  input  logic [4:0]  sa,
  input  logic [23:0] a,
  input  logic [23:0] b,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] r,
  output logic        err
);

  localparam logic [1:0] OpExtr = 2'b00;
  localparam logic [1:0] OpDep  = 2'b01;
  localparam logic [1:0] OpDsr  = 2'b10;

  logic        s1_valid_q, s2_valid_q;
  logic [1:0]  s1_op_q;
  logic        s1_sgn_q, s1_zro_q, s1_err_q;
  logic [23:0] s1_a_q, s1_b_q;
  logic [4:0]  s1_lft_q, s1_rht_q, s1_sh_q;
  logic [23:0] r_q, r_d;
  logic        err_q, err_d;

  logic        adv2, accept;
  logic [5:0]  lft_s;
  logic        s1_err_d;
  logic [4:0]  s1_sh_d;

  assign adv2      = s1_valid_q & (~s2_valid_q | out_ready);
  assign in_ready  = (~s1_valid_q | adv2) & ~flush;
  assign accept    = in_valid & in_ready;
  assign out_valid = s2_valid_q;
  assign r         = r_q;
  assign err       = err_q;

  // 6-bit signed left bound: bit 5 set means the field runs off the MSB end.
  assign lft_s = {1'b0, pos} - {1'b0, len} + 6'd1;

  always_comb begin
    s1_err_d = 1'b1;
    s1_sh_d  = 5'd23 - pos;
    case (op)
      OpExtr, OpDep: s1_err_d = (len == 5'd0) | (len > 5'd24) | (pos > 5'd23) | lft_s[5];
      OpDsr: begin
        s1_err_d = (sa > 5'd23);
        s1_sh_d  = sa;
      end
      default: s1_err_d = 1'b1;
    endcase
  end

  // Stage 2 datapath
  logic [4:0]  width_m1;
  logic [23:0] low_mask, dep_mask, ext_f, base;
  logic        ext_top;

  always_comb begin
    width_m1 = s1_rht_q - s1_lft_q;
    low_mask = 24'hFFFFFF >> (5'd23 - width_m1);
    dep_mask = low_mask << s1_sh_q;
    ext_f    = (s1_b_q >> s1_sh_q) & low_mask;
    ext_top  = |(ext_f & (low_mask ^ (low_mask >> 1)));
    base     = s1_zro_q ? 24'h0 : s1_a_q;
    r_d      = 24'h0;
    err_d    = s1_err_q;
    if (!s1_err_q) begin
      case (s1_op_q)
        OpExtr:  r_d = (s1_sgn_q && ext_top) ? (ext_f | ~low_mask) : ext_f;
        OpDep:   r_d = (base & ~dep_mask) | ((s1_b_q << s1_sh_q) & dep_mask);
        OpDsr:   r_d = 24'({s1_a_q, s1_b_q} >> s1_sh_q);
        default: r_d = 24'h0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s1_valid_q <= 1'b0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
    end else if (adv2) begin
      s1_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op_q  <= op;
      s1_sgn_q <= sgn;
      s1_zro_q <= zro;
      s1_a_q   <= a;
      s1_b_q   <= b;
      s1_lft_q <= lft_s[4:0];
      s1_rht_q <= pos;
      s1_sh_q  <= s1_sh_d;
      s1_err_q <= s1_err_d;
    end
  end

  // r/err only load on advance, so they hold while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      r_q        <= 24'h0;
      err_q      <= 1'b0;
    end else if (flush) begin
      s2_valid_q <= 1'b0;
    end else if (adv2) begin
      s2_valid_q <= 1'b1;
      r_q        <= r_d;
      err_q      <= err_d;
    end else if (s2_valid_q && out_ready) begin
      s2_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_merge_pipe_24.sv
// Bench for shift_merge_pipe_24: vector table plus scoreboard, with hand sequences for
// latency, backpressure, flush and reset.
module tb_shift_merge_pipe_24;

  typedef struct {
    logic [1:0]  op;
    logic        sgn;
    logic        zro;
    logic [4:0]  pos;
    logic [4:0]  len;
    logic [4:0]  sa;
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] r;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, sgn, zro, flush, out_valid, out_ready, err;
  logic [1:0]  op;
  logic [4:0]  pos, len, sa;
  logic [23:0] a, b, r;

  logic [23:0] drv_r;
  logic        drv_err;
  logic [24:0] sb_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          rnd_ready = 0;
  vec_t        tbl[16];

  shift_merge_pipe_24 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .sgn(sgn),
    .zro(zro), .pos(pos), .len(len), .sa(sa), .a(a), .b(b), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .r(r), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Independent bit-loop reference model; returns {err, r}.
  function automatic logic [24:0] model(input logic [1:0] o, input logic s, input logic z,
                                        input logic [4:0] ps, input logic [4:0] ln,
                                        input logic [4:0] sh, input logic [23:0] av,
                                        input logic [23:0] bv);
    int p, l, k;
    logic [23:0] res;
    logic [47:0] x;
    p = int'(ps); l = int'(ln); k = int'(sh); res = 24'h0;
    if (o == 2'b11) return {1'b1, 24'h0};
    if (o == 2'b10 && k > 23) return {1'b1, 24'h0};
    if (o != 2'b10 && (l == 0 || l > 24 || p > 23 || p - l + 1 < 0)) return {1'b1, 24'h0};
    if (o == 2'b00) begin
      for (int i = 0; i < 24; i++)
        res[i] = (i < l) ? bv[23-p+i] : (s & bv[23-p+l-1]);
    end else if (o == 2'b01) begin
      res = z ? 24'h0 : av;
      for (int i = 0; i < l; i++) res[23-p+i] = bv[i];
    end else begin
      x = {av, bv};
      for (int i = 0; i < 24; i++) res[i] = x[i+k];
    end
    return {1'b0, res};
  endfunction

  function automatic vec_t mk(input logic [1:0] o, input logic s, input logic z,
                              input logic [4:0] ps, input logic [4:0] ln, input logic [4:0] sh,
                              input logic [23:0] av, input logic [23:0] bv,
                              input logic [23:0] rv, input logic ev);
    vec_t v;
    v.op = o; v.sgn = s; v.zro = z; v.pos = ps; v.len = ln; v.sa = sh;
    v.a = av; v.b = bv; v.r = rv; v.err = ev;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    op = v.op; sgn = v.sgn; zro = v.zro; pos = v.pos; len = v.len; sa = v.sa;
    a = v.a; b = v.b; drv_r = v.r; drv_err = v.err; in_valid = 1'b1;
  endtask

  task automatic send(input vec_t v, input int max_wait, output int waited);
    bit done;
    drive(v);
    waited = 0;
    done = 0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1;
      else begin
        waited++;
        if (waited >= max_wait) begin
          checks++;
          failures++;
          $display("FAIL send_timeout actual=in_ready_low required=accept");
          done = 1;
        end
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on accept, pop on output transfer.
  always @(negedge clk) begin
    logic [24:0] e;
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", 32'(r), 32'hDEAD);
        end else begin
          e = sb_q.pop_front();
          chk("sb_r", 32'(r), 32'(e[23:0]));
          chk("sb_err", 32'(err), 32'(e[24]));
        end
      end
      if (in_valid && in_ready) sb_q.push_back({drv_err, drv_r});
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int w;
    vec_t v, va, vb, vc;
    tbl[0]  = mk(2'b00, 0, 0, 23, 8, 0, 24'h0, 24'hABCDEF, 24'h0000EF, 0);
    tbl[1]  = mk(2'b00, 1, 0, 23, 8, 0, 24'h0, 24'hABCDEF, 24'hFFFFEF, 0);
    tbl[2]  = mk(2'b00, 0, 0, 11, 4, 0, 24'h0, 24'hABCDEF, 24'h00000C, 0);
    tbl[3]  = mk(2'b01, 0, 0, 15, 4, 0, 24'h123456, 24'h00000A, 24'h123A56, 0);
    tbl[4]  = mk(2'b01, 0, 1, 15, 4, 0, 24'h123456, 24'h00000A, 24'h000A00, 0);
    tbl[5]  = mk(2'b01, 0, 0, 23, 24, 0, 24'h123456, 24'hFFFFFF, 24'hFFFFFF, 0);
    tbl[6]  = mk(2'b10, 0, 0, 23, 24, 4, 24'h000001, 24'h000000, 24'h100000, 0);
    tbl[7]  = mk(2'b10, 0, 0, 23, 24, 0, 24'h000001, 24'h000000, 24'h000000, 0);
    tbl[8]  = mk(2'b10, 0, 0, 23, 24, 24, 24'h000001, 24'h000000, 24'h000000, 1);
    tbl[9]  = mk(2'b00, 0, 0, 2, 4, 0, 24'h0, 24'hABCDEF, 24'h000000, 1);
    tbl[10] = mk(2'b00, 0, 0, 23, 0, 0, 24'h0, 24'hABCDEF, 24'h000000, 1);
    tbl[11] = mk(2'b11, 0, 0, 23, 8, 0, 24'h0, 24'hABCDEF, 24'h000000, 1);
    tbl[12] = mk(2'b00, 0, 0, 23, 24, 0, 24'h0, 24'h5A5A5A, 24'h5A5A5A, 0);
    tbl[13] = mk(2'b00, 1, 0, 0, 1, 0, 24'h0, 24'h800000, 24'hFFFFFF, 0);
    tbl[14] = mk(2'b01, 0, 0, 0, 1, 0, 24'h000000, 24'h000001, 24'h800000, 0);
    tbl[15] = mk(2'b00, 0, 0, 24, 1, 0, 24'h0, 24'hFFFFFF, 24'h000000, 1);

    rst = 1; in_valid = 0; flush = 0; out_ready = 1; op = 0; sgn = 0; zro = 0;
    pos = 0; len = 0; sa = 0; a = 0; b = 0; drv_r = 0; drv_err = 0;
    cycles(2);
    rst = 0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_r", 32'(r), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    cycles(1);

    // Latency: out_valid low one cycle after accept, high two cycles after.
    send(tbl[6], 20, w);
    @(negedge clk);
    chk("lat_cycle1", 32'(out_valid), 0);
    @(negedge clk);
    chk("lat_cycle2", 32'(out_valid), 1);
    chk("lat_r", 32'(r), 32'h100000);
    cycles(3);

    // Table streamed back to back with the consumer always ready.
    for (int i = 0; i < 16; i++) begin
      send(tbl[i], 20, w);
      chk("tput_wait", 32'(w), 0);
    end
    cycles(4);

    // Backpressure: two fill the pipe, the third waits while r holds the first.
    out_ready = 0;
    va = mk(2'b10, 0, 0, 23, 24, 1, 24'h000001, 24'h0, 24'h800000, 0);
    vb = mk(2'b10, 0, 0, 23, 24, 2, 24'h000001, 24'h0, 24'h400000, 0);
    vc = mk(2'b10, 0, 0, 23, 24, 3, 24'h000001, 24'h0, 24'h200000, 0);
    send(va, 20, w);
    send(vb, 20, w);
    chk("bp_second_wait", 32'(w), 0);
    drive(vc);
    @(negedge clk);
    chk("bp_full_in_ready", 32'(in_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    chk("bp_hold_r", 32'(r), 32'h800000);
    cycles(1);
    @(negedge clk);
    chk("bp_hold_r2", 32'(r), 32'h800000);
    cycles(1);
    out_ready = 1;
    @(negedge clk);
    chk("bp_rel_in_ready", 32'(in_ready), 1);
    chk("bp_rel_v0", 32'(out_valid), 1);
    cycles(1);
    in_valid = 0;
    @(negedge clk);
    chk("bp_rel_v1", 32'(out_valid), 1);
    chk("bp_rel_r1", 32'(r), 32'h400000);
    cycles(1);
    @(negedge clk);
    chk("bp_rel_v2", 32'(out_valid), 1);
    chk("bp_rel_r2", 32'(r), 32'h200000);
    cycles(3);

    // Flush with two in flight plus a request presented during flush.
    out_ready = 0;
    send(tbl[3], 20, w);
    send(tbl[4], 20, w);
    drive(tbl[5]);
    flush = 1;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 0);
    cycles(1);
    flush = 0;
    in_valid = 0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 0);
    cycles(1);
    out_ready = 1;
    cycles(5);
    chk("flush_sb_empty", 32'(sb_q.size()), 0);

    // Reset with two in flight.
    out_ready = 0;
    send(tbl[3], 20, w);
    send(tbl[4], 20, w);
    @(negedge clk);
    chk("prerst_r", 32'(r), 32'h123A56);
    cycles(1);
    rst = 1;
    cycles(1);
    rst = 0;
    @(negedge clk);
    chk("mrst_out_valid", 32'(out_valid), 0);
    chk("mrst_r", 32'(r), 0);
    chk("mrst_err", 32'(err), 0);
    chk("mrst_in_ready", 32'(in_ready), 1);
    cycles(1);
    out_ready = 1;
    cycles(5);
    chk("mrst_sb_empty", 32'(sb_q.size()), 0);

    // Random requests under random backpressure, checked against the model.
    rnd_ready = 1;
    for (int n = 0; n < 60; n++) begin
      v.op = 2'($urandom_range(0, 3));
      v.sgn = 1'($urandom_range(0, 1));
      v.zro = 1'($urandom_range(0, 1));
      v.pos = 5'($urandom_range(0, 25));
      v.len = 5'($urandom_range(0, 25));
      v.sa = 5'($urandom_range(0, 25));
      v.a = 24'($urandom);
      v.b = 24'($urandom);
      {v.err, v.r} = model(v.op, v.sgn, v.zro, v.pos, v.len, v.sa, v.a, v.b);
      send(v, 50, w);
    end
    rnd_ready = 0;
    @(posedge clk); #1;
    out_ready = 1;
    for (int i = 0; i < 30 && sb_q.size() != 0; i++) cycles(1);
    chk("drain_sb_empty", 32'(sb_q.size()), 0);
    cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
